// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared FSM states, legal parameter ranges and saturation limits for seq_multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int W_MIN    = 4;
  localparam int W_MAX    = 32;
  localparam int FRAC_MIN = 0;

  // Limits are returned right-aligned in 32 bits; callers cast down to W.
  function automatic logic [31:0] sat_max(input int w, input bit sgn);
    logic [63:0] v;
    v = sgn ? ((64'd1 << (w - 1)) - 64'd1) : ((64'd1 << w) - 64'd1);
    return v[31:0];
  endfunction

  function automatic logic [31:0] sat_min(input int w, input bit sgn);
    logic [63:0] v;
    v = sgn ? (64'd1 << (w - 1)) : 64'd0;
    return v[31:0];
  endfunction

endpackage

// File: rtl/adder_nbit.sv
// rtl/adder_nbit.sv - N-bit ripple-carry adder with carry in and carry out.
module adder_nbit #(
  parameter int N = 17
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < N; i++) begin
      sum[i] = x[i] ^ y[i] ^ c;
      c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - sign-magnitude shift-add fixed-point multiplier, one step per cycle.
// Define MULT_SAT_EN to clamp p on overflow instead of wrapping.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int W      = 16,
  parameter int FRAC   = 0,
  parameter int SIGNED = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] p,
  output logic         ovf,
  output logic         busy
);

  localparam int CW = $clog2(W + 1);
  localparam int PW = 2 * W + 1;

  state_t state_q, state_d;

  logic [CW-1:0] cnt_q;
  logic [W-1:0]  ma_q;
  logic [W:0]    hi_q;
  logic [W-1:0]  lo_q;
  logic          sign_q;
  logic [W-1:0]  p_q;
  logic          ovf_q;

  logic          a_neg, b_neg;
  logic [W-1:0]  a_mag, b_mag;
  logic          cnt_last;
  logic [W:0]    add_y, add_sum;
  logic          add_cout;
  logic [PW-1:0] prod, shifted;
  logic [W-1:0]  res, p_fix;
  logic          ovf_c;

  assign a_neg    = (SIGNED != 0) && a[W-1];
  assign b_neg    = (SIGNED != 0) && b[W-1];
  assign a_mag    = a_neg ? (~a + 1'b1) : a;
  assign b_mag    = b_neg ? (~b + 1'b1) : b;
  assign cnt_last = (cnt_q == CW'(W));

  // The high half carries one spare bit so the adder carry is kept, not lost.
  assign add_y = {1'b0, (lo_q[0] ? ma_q : {W{1'b0}})};

  adder_nbit #(.N(W + 1)) u_adder (
    .x    (hi_q),
    .y    (add_y),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Arithmetic shift of the signed product gives truncation toward -inf.
  always_comb begin
    prod    = sign_q ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};
    shifted = $unsigned($signed(prod) >>> FRAC);
    res     = shifted[W-1:0];
    if (SIGNED != 0) ovf_c = (shifted[PW-1:W] != {(W + 1){shifted[W-1]}});
    else             ovf_c = (shifted[PW-1:W] != '0);
`ifdef MULT_SAT_EN
    if (ovf_c) p_fix = sign_q ? W'(sat_min(W, SIGNED != 0)) : W'(sat_max(W, SIGNED != 0));
    else       p_fix = res;
`else
    p_fix = res;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_RUN;
      ST_RUN:  if (cnt_last)  state_d = ST_FIX;
      ST_FIX:                 state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
  end

  // RUN spends one settling cycle at cnt==W after the W steps, placing DONE W+2 edges after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      ma_q   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      sign_q <= 1'b0;
      p_q    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (in_valid) begin
          ma_q   <= a_mag;
          lo_q   <= b_mag;
          hi_q   <= '0;
          sign_q <= a_neg ^ b_neg;
          cnt_q  <= '0;
        end
        ST_RUN: if (!cnt_last) begin
          hi_q  <= {add_cout, add_sum[W:1]};
          lo_q  <= {add_sum[0], lo_q[W-1:1]};
          cnt_q <= cnt_q + 1'b1;
        end
        ST_FIX: begin
          p_q   <= p_fix;
          ovf_q <= ovf_c;
        end
        default: ;
      endcase
    end
  end

  assign p   = p_q;
  assign ovf = ovf_q;

endmodule
